// File: rtl/calc_pkg.sv
// Shared key codes, state/operator encodings and limits for the calculator core.
package calc_pkg;

  localparam logic [3:0] KEY_SUB = 4'd10;
  localparam logic [3:0] KEY_ADD = 4'd11;
  localparam logic [3:0] KEY_EQ  = 4'd12;
  localparam logic [3:0] KEY_CLR = 4'd13;

  localparam int MAX_VAL = 9999;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    OP_WAIT = 3'd1,
    ENTER_B = 3'd2,
    CONV    = 3'd3,
    RESULT  = 3'd4,
    ERROR   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } op_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 14-bit binary to four BCD digits, one bit per cycle.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic [15:0] bcd
);

  logic [13:0] sr_p0;
  logic [3:0]  cnt_r;
  logic [15:0] adj_c;

  function automatic logic [15:0] dabble(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign adj_c = dabble(bcd);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt_r <= 4'd0;
    end else if (start && !busy) begin
      busy  <= 1'b1;
      cnt_r <= 4'd14;
    end else if (busy) begin
      cnt_r <= cnt_r - 4'd1;
      if (cnt_r == 4'd1) busy <= 1'b0;
    end
  end

  // data path: load on start, then correct-and-shift once per busy cycle
  always_ff @(posedge clk) begin
    if (start && !busy) begin
      sr_p0 <= bin;
      bcd   <= 16'd0;
    end else if (busy) begin
      sr_p0 <= {sr_p0[12:0], 1'b0};
      bcd   <= {adj_c[14:0], sr_p0[13]};
    end
  end

endmodule

// File: rtl/calc_core.sv
// Four-digit chained add/subtract calculator driven by keyboard tokens.
module calc_core
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  digit_i,
  input  logic        new_data_i,
  output logic [15:0] bcd_o,
  output logic        neg_o,
  output logic        err_o,
  output logic [1:0]  op_o,
  output logic        busy_o
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  state_e                state_r, after_conv_r;
  op_e                   op_r, next_op_r;
  logic signed [14:0]    a_r;
  logic        [13:0]    b_r;
  logic        [CNT_W-1:0] cnt_r;
  logic signed [15:0]    res_r;
  logic                  started_r;

  logic                  key_clr, key_ok, room;
  op_e                   key_op;
  logic signed [15:0]    a_ext, b_ext, sum_c;
  logic        [15:0]    mag_c;
  logic                  ovf_c, conv_start, b2b_busy;
  logic        [15:0]    b2b_bcd;

  assign key_clr = new_data_i && (digit_i == KEY_CLR);
  assign key_ok  = new_data_i && !busy_o;
  assign room    = cnt_r < CNT_W'(MAX_DIGITS);
  assign key_op  = (digit_i == KEY_SUB) ? OP_SUB : OP_ADD;

  assign a_ext = {a_r[14], a_r};
  assign b_ext = {2'b00, b_r};
  assign sum_c = (op_r == OP_SUB) ? a_ext - b_ext : a_ext + b_ext;
  assign mag_c = res_r[15] ? 16'(-res_r) : 16'(res_r);
  assign ovf_c = mag_c > 16'(MAX_VAL);

  // first CONV cycle hands the magnitude to the converter
  assign conv_start = (state_r == CONV) && !started_r;

  bin2bcd_seq u_b2b (
    .clk   (clk_i),
    .rst   (rst_i || key_clr),
    .start (conv_start),
    .bin   (mag_c[13:0]),
    .busy  (b2b_busy),
    .bcd   (b2b_bcd)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || key_clr) begin
      state_r      <= ENTER_A;
      after_conv_r <= ENTER_A;
      op_r         <= OP_NONE;
      next_op_r    <= OP_NONE;
      a_r          <= '0;
      b_r          <= '0;
      cnt_r        <= '0;
      res_r        <= '0;
      started_r    <= 1'b0;
      bcd_o        <= '0;
      neg_o        <= 1'b0;
      err_o        <= 1'b0;
      busy_o       <= 1'b0;
    end else if (state_r == CONV) begin
      if (!started_r) begin
        started_r <= 1'b1;
      end else if (!b2b_busy) begin
        started_r <= 1'b0;
        busy_o    <= 1'b0;
        if (ovf_c) begin
          state_r <= ERROR;
          err_o   <= 1'b1;
          bcd_o   <= '0;
          neg_o   <= 1'b0;
          op_r    <= OP_NONE;
        end else begin
          state_r <= after_conv_r;
          bcd_o   <= b2b_bcd;
          neg_o   <= res_r[15];
          a_r     <= res_r[14:0];
          b_r     <= '0;
          cnt_r   <= '0;
          op_r    <= (after_conv_r == OP_WAIT) ? next_op_r : OP_NONE;
        end
      end
    end else if (key_ok) begin
      case (state_r)
        ENTER_A: begin
          if (is_digit(digit_i)) begin
            if (room) begin
              bcd_o <= {bcd_o[11:0], digit_i};
              a_r   <= a_r * 15'sd10 + {11'd0, digit_i};
              cnt_r <= cnt_r + 1'b1;
            end
          end else if (digit_i == KEY_ADD || digit_i == KEY_SUB) begin
            op_r    <= key_op;
            state_r <= OP_WAIT;
          end
        end
        OP_WAIT: begin
          if (is_digit(digit_i)) begin
            b_r     <= {10'd0, digit_i};
            bcd_o   <= {12'd0, digit_i};
            neg_o   <= 1'b0;
            cnt_r   <= CNT_W'(1);
            state_r <= ENTER_B;
          end else if (digit_i == KEY_ADD || digit_i == KEY_SUB) begin
            op_r <= key_op;
          end
        end
        ENTER_B: begin
          if (is_digit(digit_i)) begin
            if (room) begin
              bcd_o <= {bcd_o[11:0], digit_i};
              b_r   <= b_r * 14'd10 + {10'd0, digit_i};
              cnt_r <= cnt_r + 1'b1;
            end
          end else if (digit_i == KEY_ADD || digit_i == KEY_SUB || digit_i == KEY_EQ) begin
            res_r   <= sum_c;
            busy_o  <= 1'b1;
            state_r <= CONV;
            if (digit_i == KEY_EQ) begin
              after_conv_r <= RESULT;
              op_r         <= OP_NONE;
            end else begin
              after_conv_r <= OP_WAIT;
              next_op_r    <= key_op;
            end
          end
        end
        RESULT: begin
          if (is_digit(digit_i)) begin
            a_r     <= {11'd0, digit_i};
            bcd_o   <= {12'd0, digit_i};
            neg_o   <= 1'b0;
            cnt_r   <= CNT_W'(1);
            op_r    <= OP_NONE;
            state_r <= ENTER_A;
          end else if (digit_i == KEY_ADD || digit_i == KEY_SUB) begin
            op_r    <= key_op;
            state_r <= OP_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  assign op_o = op_r;

endmodule

// File: tb/tb_calc_core.sv
// Directed bench for calc_core: entry, arithmetic, chaining, overflow, busy drop, reset abort.
module tb_calc_core;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  digit_i;
  logic        new_data_i;
  logic [15:0] bcd_o;
  logic        neg_o, err_o, busy_o;
  logic [1:0]  op_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_busy;

  calc_core #(.MAX_DIGITS(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .digit_i    (digit_i),
    .new_data_i (new_data_i),
    .bcd_o      (bcd_o),
    .neg_o      (neg_o),
    .err_o      (err_o),
    .op_o       (op_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk_i);
    digit_i    = k;
    new_data_i = 1'b1;
    @(negedge clk_i);
    new_data_i = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o && n < 40) begin
      n++;
      @(negedge clk_i);
    end
  endtask

  initial begin
    rst_i      = 1'b1;
    digit_i    = 4'd0;
    new_data_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_bcd", 32'(bcd_o), 32'h0);
    check("rst_neg", 32'(neg_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_op", 32'(op_o), 32'd0);

    // entry with truncation after four digits
    press(4'd1); check("entry1", 32'(bcd_o), 32'h0001);
    press(4'd2); check("entry2", 32'(bcd_o), 32'h0012);
    press(4'd3); check("entry3", 32'(bcd_o), 32'h0123);
    press(4'd4); check("entry4", 32'(bcd_o), 32'h1234);
    press(4'd5); check("entry5", 32'(bcd_o), 32'h1234);
    press(4'd13); check("clr_bcd", 32'(bcd_o), 32'h0);

    // 12 + 34 = 46
    press(4'd1); press(4'd2);
    press(4'd11);
    check("add_op", 32'(op_o), 32'd1);
    check("add_disp_hold", 32'(bcd_o), 32'h0012);
    press(4'd3); check("add_b1", 32'(bcd_o), 32'h0003);
    press(4'd4); check("add_b2", 32'(bcd_o), 32'h0034);
    press(4'd12);
    check("add_busy_start", 32'(busy_o), 32'd1);
    check("add_conv_hold", 32'(bcd_o), 32'h0034);
    wait_idle(n_busy);
    check("add_busy_len", 32'(n_busy), 32'd16);
    check("add_bcd", 32'(bcd_o), 32'h0046);
    check("add_neg", 32'(neg_o), 32'd0);
    check("add_op_after", 32'(op_o), 32'd0);

    // 5 - 12 = -7, then -7 + 3 = -4
    press(4'd5); check("sub_freshA", 32'(bcd_o), 32'h0005);
    press(4'd10); check("sub_op", 32'(op_o), 32'd2);
    press(4'd1); press(4'd2); press(4'd12);
    wait_idle(n_busy);
    check("sub_bcd", 32'(bcd_o), 32'h0007);
    check("sub_neg", 32'(neg_o), 32'd1);
    press(4'd11); check("chain_op", 32'(op_o), 32'd1);
    check("chain_disp", 32'(bcd_o), 32'h0007);
    press(4'd3); press(4'd12);
    wait_idle(n_busy);
    check("chain_bcd", 32'(bcd_o), 32'h0004);
    check("chain_neg", 32'(neg_o), 32'd1);

    // operator in ENTER_B chains: 2 + 3 - 1 = 4
    press(4'd13);
    press(4'd2); press(4'd11); press(4'd3); press(4'd10);
    wait_idle(n_busy);
    check("opchain_bcd", 32'(bcd_o), 32'h0005);
    check("opchain_op", 32'(op_o), 32'd2);
    press(4'd1); press(4'd12);
    wait_idle(n_busy);
    check("opchain_res", 32'(bcd_o), 32'h0004);
    check("opchain_neg", 32'(neg_o), 32'd0);

    // 9999 + 1 overflows
    press(4'd13);
    press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    press(4'd11); press(4'd1); press(4'd12);
    wait_idle(n_busy);
    check("ovf_err", 32'(err_o), 32'd1);
    check("ovf_bcd", 32'(bcd_o), 32'h0);
    check("ovf_op", 32'(op_o), 32'd0);
    press(4'd5); press(4'd11); press(4'd12);
    check("ovf_hold_err", 32'(err_o), 32'd1);
    check("ovf_hold_bcd", 32'(bcd_o), 32'h0);
    check("ovf_hold_op", 32'(op_o), 32'd0);
    press(4'd13);
    check("ovf_clr_err", 32'(err_o), 32'd0);
    press(4'd3); check("ovf_clr_entry", 32'(bcd_o), 32'h0003);

    // digit during busy is dropped: 2 + 3 = 5
    press(4'd13);
    press(4'd2); press(4'd11); press(4'd3); press(4'd12);
    press(4'd9);
    wait_idle(n_busy);
    check("drop_bcd", 32'(bcd_o), 32'h0005);
    check("drop_neg", 32'(neg_o), 32'd0);

    // reset aborts a conversion
    press(4'd13);
    press(4'd4); press(4'd11); press(4'd5); press(4'd12);
    repeat (3) @(negedge clk_i);
    check("abort_busy_pre", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("abort_bcd", 32'(bcd_o), 32'h0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_op", 32'(op_o), 32'd0);
    press(4'd7); check("abort_entry", 32'(bcd_o), 32'h0007);
    press(4'd11); press(4'd8); press(4'd12);
    wait_idle(n_busy);
    check("abort_next_len", 32'(n_busy), 32'd16);
    check("abort_next_bcd", 32'(bcd_o), 32'h0015);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_core.md
# calc_core

Four-digit add/subtract calculator core sitting directly downstream of the PS/2 keyboard receiver. It consumes one key token per `new_data_i` pulse and builds decimal operands. It performs chained signed addition and subtraction, and presents the current entry or result as BCD magnitude plus sign for the display driver.

## Interface
- `MAX_DIGITS`, 4: maximum entered digits per operand.
- `clk_i` input 1: system clock; single clock domain.
- `rst_i` input 1: synchronous, active-high reset.
- `digit_i` input 4: key token from the receiver.
  - 0–9: digits.
  - 10: minus.
  - 11: plus.
  - 12: equals.
  - 13: clear.
  - 14–15: ignored.
- `new_data_i` input 1: one-cycle strobe; `digit_i` is valid in that cycle.
- `bcd_o` output 16: four BCD digits of the displayed magnitude, most-significant digit in [15:12].
- `neg_o` output 1: displayed value is negative.
- `err_o` output 1: overflow error latched.
- `op_o` output 2: pending operator (0 none, 1 add, 2 sub).
- `busy_o` output 1: result conversion in progress.

## Operation
- **States:** ENTER_A, OP_WAIT, ENTER_B, CONV, RESULT, ERROR.
- **Reset:** state ENTER_A; all outputs 0; accumulator A = 0; operand B = 0; digit count = 0.
- **Key acceptance:** a key is accepted only when `new_data_i` = 1 and `busy_o` = 0. Keys arriving while `busy_o` = 1 are dropped silently.
- **Digit entry (ENTER_A / ENTER_B):**
  - While count < `MAX_DIGITS`: BCD entry register shifts left 4 with the digit inserted; binary operand updates as bin*10 + d; count increments.
  - Further digits are ignored.
  - `bcd_o` shows the entry register; `neg_o` = 0.
- **Digit in OP_WAIT:** clears B, enters the digit, goes to ENTER_B.
- **Digit in RESULT:** starts a fresh A (A = d), goes to ENTER_A, `op_o` = 0.
- **Operator in ENTER_A or RESULT:** latches A (in RESULT, A is the signed result); sets `op_o`; goes to OP_WAIT. The display is unchanged.
- **Operator in OP_WAIT:** replaces `op_o` only.
- **Operator in ENTER_B:** computes A op B and starts CONV. The new operator is stored and becomes pending once conversion ends; the state after CONV is OP_WAIT (chaining).
- **Equals:**
  - In ENTER_B: computes A op B, starts CONV, next state RESULT, `op_o` = 0.
  - In all other states: ignored.
- **Clear:** valid in any state including ERROR and CONV (clear is the one key accepted while busy). Effect is identical to reset.
- **Arithmetic widths:**
  - A is 15-bit signed.
  - B is 14-bit unsigned.
  - The result is computed 16-bit signed.
- **Overflow:** if |result| > 9999, go to ERROR.
  - `err_o` = 1, `bcd_o` = 0, `neg_o` = 0, `op_o` = 0.
  - Only clear exits ERROR.
- **Negative result:** `neg_o` = 1 and `bcd_o` holds the magnitude. -0 never occurs; a zero result has `neg_o` = 0.

## Timing
- **Digit entry:** `bcd_o` updates on the clock edge after the `new_data_i` cycle (1-cycle latency).
- **CONV:**
  - Cycle 1: compute result and load magnitude.
  - Then 14 double-dabble cycles.
  - Final cycle: write `bcd_o` / `neg_o`.
- **`busy_o`:** high from the edge after the triggering strobe for 16 cycles. Result outputs are valid when `busy_o` falls.
- **Display during CONV:** `bcd_o` holds the previous display value.
- **Reset:** reset during CONV aborts conversion; all outputs are 0 on the next edge.
- Simultaneous reset and strobe: reset wins.

## Structure
- **`calc_pkg` contents:**
  - Key codes `KEY_SUB` = 10, `KEY_ADD` = 11, `KEY_EQ` = 12, `KEY_CLR` = 13.
  - State encoding.
  - `op_o` encoding.
  - `MAX_VAL` = 9999.
- **Sub-module `bin2bcd_seq`:** 14-bit binary to 4-digit BCD, sequential double-dabble.
  - Ports: `start`, `bin`, `busy`, `bcd`.
  - Runs one bit per cycle.
  - `start` is ignored while `busy`.
- The top level holds the FSM, entry registers and adder/subtractor.

## Test plan
- **Reset values:** assert `rst_i` for 2 cycles → `bcd_o` = 0x0000, `neg_o` = `err_o` = `busy_o` = 0, `op_o` = 0.
- **Digit entry and truncation:** enter digits 1, 2, 3, 4, 5 → `bcd_o` = 0x0001, 0x0012, 0x0123, 0x1234, 0x1234 after successive strobes.
- **Addition:** 1, 2, 11, 3, 4, 12 → `busy_o` high for 16 cycles, then `bcd_o` = 0x0046, `neg_o` = 0, `op_o` = 0.
- **Subtraction and chaining:**
  - 5, 10, 1, 2, 12 → `bcd_o` = 0x0007, `neg_o` = 1.
  - Then 11, 3, 12 → `bcd_o` = 0x0004, `neg_o` = 1.
- **Overflow error:**
  - 9, 9, 9, 9, 11, 1, 12 → `err_o` = 1, `bcd_o` = 0.
  - Further digits and operators leave outputs unchanged.
  - 13 → all outputs 0, state ENTER_A.
- **Busy and reset abort:**
  - A digit strobe while `busy_o` = 1 is dropped; the result is unaffected.
  - `rst_i` asserted mid-CONV → all outputs 0 on the next edge; a following digit 7 gives `bcd_o` = 0x0007.
